// File: rtl/top_2_pkg.sv
// Shared types for the push-button bus demonstrator: config field indices,
// master FSM states, slave ids and the per-master transfer configuration.
package top_2_pkg;

    localparam logic [2:0] FIELD_ADDR   = 3'd0;
    localparam logic [2:0] FIELD_MASTER = 3'd1;
    localparam logic [2:0] FIELD_SLAVE  = 3'd2;
    localparam logic [2:0] FIELD_BURST  = 3'd3;
    localparam logic [2:0] FIELD_WDATA  = 3'd4;
    localparam logic [2:0] FIELD_LAST   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } master_state_t;

    typedef enum logic [1:0] {
        SLV_S1 = 2'd0,
        SLV_S2 = 2'd1,
        SLV_S3 = 2'd2
    } slave_id_t;

    typedef struct packed {
        logic [7:0] addr;
        slave_id_t  target;
        logic [3:0] burst;
        logic [7:0] wdata;
    } master_cfg_t;

    function automatic slave_id_t next_slave(input slave_id_t s);
        case (s)
            SLV_S1:  return SLV_S2;
            SLV_S2:  return SLV_S3;
            default: return SLV_S1;
        endcase
    endfunction

endpackage

// File: rtl/top_2_if.sv
// Internal bus between one master and the arbiter/slave side: request, grant,
// ownership hold and one data beat per tick.
interface top_2_if;
    import top_2_pkg::*;

    logic      req;
    logic      gnt;
    logic      hold;
    logic      valid;
    logic      we;
    slave_id_t target;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output req, hold, valid, we, target, addr, wdata,
                    input  gnt, rdata);
    modport slave  (input  req, hold, valid, we, target, addr, wdata,
                    output gnt, rdata);
endinterface

// File: rtl/top_2_bus_master.sv
// One bus master: config registers, IDLE->REQ->ADDR->DATA FSM stepping on
// ticks, beat counter and the read-back register.
module bus_master
    import top_2_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       rw,
    input  logic       cfg_commit,
    input  logic [2:0] cfg_field,
    input  logic [7:0] cfg_value,
    output logic       busy,
    output logic [7:0] rd_data,
    top_2_if.master    bus
);
    master_state_t state, state_next;
    master_cfg_t   cfg;
    logic          dir_read;
    logic [3:0]    beat;
    logic          last_beat;

    assign last_beat = (beat == cfg.burst);

    always_ff @(posedge clock) begin
        if (rst) begin
            cfg <= '{addr: '0, target: SLV_S1, burst: '0, wdata: '0};
        end else if (cfg_commit) begin
            case (cfg_field)
                FIELD_ADDR:  cfg.addr   <= cfg_value;
                FIELD_SLAVE: cfg.target <= next_slave(cfg.target);
                FIELD_BURST: cfg.burst  <= cfg_value[3:0];
                FIELD_WDATA: cfg.wdata  <= cfg_value;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_IDLE: if (start)   state_next = ST_REQ;
                ST_REQ:  if (bus.gnt) state_next = ST_ADDR;
                ST_ADDR:              state_next = ST_DATA;
                ST_DATA: if (last_beat) state_next = ST_IDLE;
                default:              state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            dir_read <= 1'b0;
            beat     <= '0;
            rd_data  <= '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: if (start) dir_read <= rw;
                ST_ADDR: beat <= '0;
                ST_DATA: begin
                    if (dir_read) rd_data <= bus.rdata;
                    beat <= beat + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign bus.req   = (state == ST_REQ);
    // Ownership ends on the last beat so a waiting master is granted on that same tick.
    assign bus.hold  = (state == ST_ADDR) || ((state == ST_DATA) && !last_beat);
    assign bus.valid = (state == ST_DATA);
    assign bus.we    = !dir_read;
    assign bus.target = cfg.target;
    assign bus.addr  = cfg.addr + {4'd0, beat};
    assign bus.wdata = cfg.wdata + {4'd0, beat};

endmodule

// File: rtl/top_2.sv
// Board-level demonstrator: clock divider, button conditioning, config panel,
// two bus masters, fixed-priority arbiter and three slave memories.
module top_2
    import top_2_pkg::*;
#(
    parameter int SCALE     = 10,
    parameter int MEM_DEPTH = 256
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        enable,
    input  logic        button1_raw,
    input  logic        button2_raw,
    input  logic        button3_raw,
    input  logic        mode_switch,
    input  logic        rw_switch1,
    input  logic        rw_switch2,
    input  logic [11:0] switch_array,
    output logic        m1_busy,
    output logic        m2_busy,
    output logic        scaled_clk
);
    localparam int CW = $clog2(SCALE);
    localparam logic [CW-1:0] LAST_COUNT = CW'(SCALE - 1);
    localparam logic [CW-1:0] HALF_COUNT = CW'(SCALE / 2);

    logic [CW-1:0] count;
    logic          tick;

    // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (rst)         count <= '0;
        else if (enable) count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
    end

    assign tick       = enable && (count == LAST_COUNT);
    assign scaled_clk = (count >= HALF_COUNT);

    logic [2:0] sync_a, sync_b;
    logic [1:0] sampled;
    logic       ev1, ev2, adv;

    always_ff @(posedge clock) begin
        if (rst) begin
            sync_a  <= '0;
            sync_b  <= '0;
            sampled <= '0;
        end else if (enable) begin
            sync_a <= ~{button3_raw, button2_raw, button1_raw};
            sync_b <= sync_a;
            if (tick) sampled <= sync_b[1:0];
        end
    end

    assign ev1 = tick && sync_b[0] && !sampled[0];
    assign ev2 = tick && sync_b[1] && !sampled[1];
    assign adv = tick && sync_b[2];

    logic [2:0] field_idx;
    logic       sel_m2;

    always_ff @(posedge clock) begin
        if (rst) begin
            field_idx <= FIELD_ADDR;
            sel_m2    <= 1'b0;
        end else if (!mode_switch) begin
            if (adv) field_idx <= (field_idx == FIELD_LAST) ? FIELD_ADDR : field_idx + 3'd1;
            if (ev1 && field_idx == FIELD_MASTER) sel_m2 <= !sel_m2;
        end
    end

    logic commit1, commit2, start1, start2;
    assign commit1 = !mode_switch && ev1 && !sel_m2;
    assign commit2 = !mode_switch && ev1 &&  sel_m2;
    assign start1  =  mode_switch && ev1;
    assign start2  =  mode_switch && ev2;

    top_2_if if_m1 ();
    top_2_if if_m2 ();
    logic [7:0] m1_rd_data, m2_rd_data;

    bus_master u_m1 (
        .clock(clock), .rst(rst), .tick(tick), .start(start1), .rw(rw_switch1),
        .cfg_commit(commit1), .cfg_field(field_idx), .cfg_value(switch_array[7:0]),
        .busy(m1_busy), .rd_data(m1_rd_data), .bus(if_m1)
    );

    bus_master u_m2 (
        .clock(clock), .rst(rst), .tick(tick), .start(start2), .rw(rw_switch2),
        .cfg_commit(commit2), .cfg_field(field_idx), .cfg_value(switch_array[7:0]),
        .busy(m2_busy), .rd_data(m2_rd_data), .bus(if_m2)
    );

    // Fixed priority: M1 wins a simultaneous request; an owner keeps the bus until its last beat.
    assign if_m1.gnt = if_m1.req && !if_m2.hold;
    assign if_m2.gnt = if_m2.req && !if_m1.req && !if_m1.hold;

    logic       bus_valid, bus_we;
    slave_id_t  bus_target;
    logic [7:0] bus_addr, bus_wdata, bus_rdata;

    always_comb begin
        // NOTE: each output of a combinational block is defaulted first so no latch is inferred.
        bus_valid  = if_m1.valid || if_m2.valid;
        bus_we     = if_m1.we;
        bus_target = if_m1.target;
        bus_addr   = if_m1.addr;
        bus_wdata  = if_m1.wdata;
        if (if_m2.valid) begin
            bus_we     = if_m2.we;
            bus_target = if_m2.target;
            bus_addr   = if_m2.addr;
            bus_wdata  = if_m2.wdata;
        end
    end

    logic [7:0] mem_s1 [MEM_DEPTH];
    logic [7:0] mem_s2 [MEM_DEPTH];
    logic [7:0] mem_s3 [MEM_DEPTH];

    // NOTE: the memories have no reset, so their contents survive rst.
    always_ff @(posedge clock) begin
        if (tick && bus_valid && bus_we) begin
            case (bus_target)
                SLV_S2:  mem_s2[bus_addr] <= bus_wdata;
                SLV_S3:  mem_s3[bus_addr] <= bus_wdata;
                default: mem_s1[bus_addr] <= bus_wdata;
            endcase
        end
    end

    always_comb begin
        case (bus_target)
            SLV_S2:  bus_rdata = mem_s2[bus_addr];
            SLV_S3:  bus_rdata = mem_s3[bus_addr];
            default: bus_rdata = mem_s1[bus_addr];
        endcase
    end

    assign if_m1.rdata = bus_rdata;
    assign if_m2.rdata = bus_rdata;

    // Upper switch bits and the read-back registers have no consumer on this board.
    logic unused_bits;
    assign unused_bits = ^{switch_array[11:8], m1_rd_data, m2_rd_data};

endmodule

// File: tb/tb_top_2.sv
// Directed bench for top_2: divider, config panel, single/burst transfers,
// arbitration, dropped starts, mid-burst reset and enable freeze.
module tb_top_2;
    localparam int SCALE = 10;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        button1_raw = 1'b1;
    logic        button2_raw = 1'b1;
    logic        button3_raw = 1'b1;
    logic        mode_switch = 1'b0;
    logic        rw_switch1 = 1'b0;
    logic        rw_switch2 = 1'b0;
    logic [11:0] switch_array = '0;
    logic        m1_busy, m2_busy, scaled_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cur_field = 0;
    bit sel_model = 1'b0;

    top_2 #(.SCALE(SCALE), .MEM_DEPTH(256)) dut (
        .clock(clock), .rst(rst), .enable(enable),
        .button1_raw(button1_raw), .button2_raw(button2_raw), .button3_raw(button3_raw),
        .mode_switch(mode_switch), .rw_switch1(rw_switch1), .rw_switch2(rw_switch2),
        .switch_array(switch_array),
        .m1_busy(m1_busy), .m2_busy(m2_busy), .scaled_clk(scaled_clk)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold one button for a whole number of scaled periods, then leave a gap.
    task automatic hold_button(input int which, input int periods);
        for (int i = 0; i < periods * SCALE; i++) begin
            @(negedge clock);
            case (which)
                1:       button1_raw = 1'b0;
                2:       button2_raw = 1'b0;
                default: button3_raw = 1'b0;
            endcase
        end
        @(negedge clock);
        button1_raw = 1'b1;
        button2_raw = 1'b1;
        button3_raw = 1'b1;
        repeat (2 * SCALE) @(negedge clock);
    endtask

    task automatic goto_field(input int f);
        int n;
        n = (f - cur_field + 7) % 7;
        if (n > 0) hold_button(3, n);
        cur_field = f;
    endtask

    task automatic commit(input logic [11:0] v);
        switch_array = v;
        hold_button(1, 1);
        if (cur_field == 1) sel_model = !sel_model;
    endtask

    // Press start button(s) for one period and count busy clocks until both masters are idle.
    task automatic run_txn(input bit p1, input bit p2, input int repress_at,
                           input int rst_at, input int freeze_at,
                           output int len1, output int len2);
        bit timed_out;
        bit stable;
        logic frozen;
        timed_out = 1'b1;
        len1 = 0;
        len2 = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            button1_raw = !(p1 && (cyc < SCALE ||
                           (repress_at > 0 && len1 >= repress_at && len1 < repress_at + SCALE)));
            button2_raw = !(p2 && cyc < SCALE);
            len1 += int'(m1_busy);
            len2 += int'(m2_busy);
            if (rst_at > 0 && len1 == rst_at) begin
                rst = 1'b1;
                @(negedge clock);
                rst = 1'b0;
                button1_raw = 1'b1;
                check("rst_busy", {m1_busy, m2_busy}, 32'd0);
                cur_field = 0;
                sel_model = 1'b0;
                timed_out = 1'b0;
                break;
            end
            if (freeze_at > 0 && len1 == freeze_at) begin
                frozen = scaled_clk;
                stable = 1'b1;
                enable = 1'b0;
                repeat (20) begin
                    @(negedge clock);
                    len1 += int'(m1_busy);
                    len2 += int'(m2_busy);
                    if (scaled_clk !== frozen) stable = 1'b0;
                end
                enable = 1'b1;
                check("freeze_sclk", stable, 32'd1);
            end
            if (cyc > 3 * SCALE && !m1_busy && !m2_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        button1_raw = 1'b1;
        button2_raw = 1'b1;
        check("txn_timeout", timed_out, 32'd0);
        repeat (2 * SCALE) @(negedge clock);
    endtask

    initial begin
        logic [19:0] pat, exp_pat;
        int len1, len2;

        repeat (10) @(negedge clock);
        check("rst_sclk", scaled_clk, 32'd0);
        check("rst_m1_busy", m1_busy, 32'd0);
        check("rst_m2_busy", m2_busy, 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            pat[j]     = scaled_clk;
            exp_pat[j] = ((j % SCALE) >= SCALE / 2);
            @(negedge clock);
        end
        check("sclk_pattern", pat, exp_pat);

        // Config: select M2, move it to S2, give it write data 0xA5.
        goto_field(1);
        check("field_idx_1", dut.field_idx, 32'd1);
        commit(12'h000);
        check("sel_m2", dut.sel_m2, sel_model);
        goto_field(2);
        commit(12'h000);
        check("m2_slave_s2", dut.u_m2.cfg.target, 32'd1);
        hold_button(3, 5);
        cur_field = 0;
        check("field_wrap", dut.field_idx, 32'd0);
        goto_field(4);
        commit(12'hFA5);
        check("m2_wdata", dut.u_m2.cfg.wdata, 32'hA5);
        goto_field(0);
        check("field_wrap2", dut.field_idx, 32'd0);

        mode_switch = 1'b1;
        rw_switch2  = 1'b0;
        run_txn(1'b0, 1'b1, 0, 0, 0, len1, len2);
        check("m2_single_len", len2, 32'(3 * SCALE));
        check("m1_idle_len", len1, 32'd0);
        check("s2_0", dut.mem_s2[0], 32'hA5);

        // M1: burst of 11 beats from address 0 with data 0x05.
        mode_switch = 1'b0;
        goto_field(1);
        commit(12'h000);
        check("sel_m1", dut.sel_m2, sel_model);
        goto_field(3);
        commit(12'h00A);
        goto_field(4);
        commit(12'h005);
        mode_switch = 1'b1;
        rw_switch1  = 1'b0;
        run_txn(1'b1, 1'b0, 50, 0, 0, len1, len2);
        check("m1_burst_wr_len", len1, 32'(13 * SCALE));
        for (int k = 0; k <= 10; k++)
            check($sformatf("s1_%0d", k), dut.mem_s1[k], 32'(5 + k));
        rw_switch1 = 1'b1;
        run_txn(1'b1, 1'b0, 0, 0, 0, len1, len2);
        check("m1_burst_rd_len", len1, 32'(13 * SCALE));
        check("m1_rd_data", dut.m1_rd_data, 32'h0F);

        // Contention: both single beats started on the same tick.
        mode_switch = 1'b0;
        goto_field(3);
        commit(12'h000);
        mode_switch = 1'b1;
        rw_switch1  = 1'b0;
        rw_switch2  = 1'b0;
        run_txn(1'b1, 1'b1, 0, 0, 0, len1, len2);
        check("arb_m1_len", len1, 32'(3 * SCALE));
        check("arb_m2_len", len2, 32'(5 * SCALE));

        // Reset in the middle of a burst at 0x20 with data 0x40.
        mode_switch = 1'b0;
        goto_field(3);
        commit(12'h00A);
        goto_field(0);
        commit(12'h020);
        goto_field(4);
        commit(12'h040);
        mode_switch = 1'b1;
        run_txn(1'b1, 1'b0, 0, 45, 0, len1, len2);
        check("partial_beat0", dut.mem_s1[32'h20], 32'h40);
        check("partial_beat1", dut.mem_s1[32'h21], 32'h41);
        check("rst_cfg_burst", dut.u_m1.cfg.burst, 32'd0);
        check("rst_field_idx", dut.field_idx, 32'd0);
        repeat (2 * SCALE) @(negedge clock);
        run_txn(1'b1, 1'b0, 0, 0, 0, len1, len2);
        check("post_rst_len", len1, 32'(3 * SCALE));
        check("post_rst_s1_0", dut.mem_s1[0], 32'h00);

        // Enable dropped for 20 clocks inside a 5-beat burst.
        mode_switch = 1'b0;
        goto_field(3);
        commit(12'h004);
        goto_field(4);
        commit(12'h060);
        mode_switch = 1'b1;
        run_txn(1'b1, 1'b0, 0, 0, 35, len1, len2);
        check("freeze_len", len1, 32'(7 * SCALE + 20));
        check("freeze_s1_0", dut.mem_s1[0], 32'h60);
        check("freeze_s1_4", dut.mem_s1[4], 32'h64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/top_2.md
Name: top_2

Overview:
- Push-button/switch demonstrator for the two-master, three-slave system bus.
- Divides the board clock into a slow bus clock and conditions three active-low buttons.
- In config mode the user sets per-master transfer fields; in run mode each master performs a single or burst read/write to an internal slave memory through a fixed-priority arbiter.
- Only busy flags and the scaled clock leave the block.

Parameters:
- SCALE, 10, clock cycles per scaled_clk period (even, >=4).
- MEM_DEPTH, 256, bytes per slave memory; addresses use the low 8 bits.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, the divider, button conditioning and all FSMs hold state.
- button1_raw  in  1  active-low. Run mode: start master 1. Config mode: commit field.
- button2_raw  in  1  active-low. Run mode: start master 2. Ignored in config mode.
- button3_raw  in  1  active-low. Config mode: advance field index. Ignored in run mode.
- mode_switch  in  1  0 = config, 1 = run.
- rw_switch1  in  1  master 1 direction: 0 = write, 1 = read; sampled at start.
- rw_switch2  in  1  master 2 direction, same encoding.
- switch_array  in  12  value source for config fields.
- m1_busy  out  1  master 1 transaction in progress.
- m2_busy  out  1  master 2 transaction in progress.
- scaled_clk  out  1  divided clock.

Behaviour:
- Reset (rst=1 at clock edge) clears:
  - divider count and scaled_clk to 0; busy outputs to 0;
  - field index to 0; selected master to M1;
  - both masters' config to zero, with slave set to S1;
  - slave memories are not cleared.
- Divider: count runs 0..SCALE-1. scaled_clk = 1 when count >= SCALE/2. Tick = one-cycle pulse when count = SCALE-1.
- Buttons: each input is double-flop synchronized and inverted (pressed = 1), then sampled only on ticks.
  - button3 is level-repeat: each tick it reads pressed gives one advance. A 1-period hold gives exactly 1 advance; a 3-period hold gives 3.
  - button1/button2 are edge events: a tick that reads pressed after a tick that read released gives one event.
- Config mode (mode_switch=0):
  - button3 advances the field index 0..6, wrapping 6 to 0.
  - A button1 event acts on the selected master, by field:
    - 0: address <= switch_array[7:0].
    - 1: toggle the selected master (M1/M2).
    - 2: slave target advances S1->S2->S3->S1.
    - 3: burst length N <= switch_array[3:0]; N = 0 means a single beat.
    - 4: write data <= switch_array[7:0].
    - 5, 6: reserved, no effect.
- Run mode (mode_switch=1):
  - A button1/button2 event starts a master only when it is IDLE; events while busy are dropped.
  - The direction is latched at the start.
- Master FSM, stepping on ticks: IDLE -> REQ -> ADDR -> DATA -> IDLE.
  - busy rises the clock after the start tick. It stays high through REQ/ADDR/DATA and falls the clock after the final DATA tick.
  - REQ: wait for grant. ADDR takes 1 tick.
  - DATA takes N+1 ticks. Beat k uses address (addr+k) mod 256.
  - Write beat k stores wdata+k (8-bit wrap) into the target slave.
  - Read beat k loads the master's rd_data register.
- Arbiter:
  - A grant is evaluated on ticks; M1 wins simultaneous requests.
  - The grant is held until the owner leaves DATA.
  - A losing master stays in REQ with busy high.
- Uncontended latency: busy is high for exactly N+3 ticks.
- Mode changes during a transaction do not abort it.
- rst mid-transaction returns both masters to IDLE with busy low; partially written memory is kept.

Decomposition:
- Package top_2_pkg:
  - field index constants (0..6);
  - master state enum (IDLE/REQ/ADDR/DATA);
  - slave id encoding (S1..S3).
- Sub-module bus_master, instantiated twice: per-master config registers, FSM, beat counter and rd_data.
- Divider, button conditioning, arbiter and slave memories stay in top_2.

Test Plan:
- Reset 10 cycles -> scaled_clk=0, m1_busy=m2_busy=0. After release, scaled_clk is low 5 / high 5 clocks.
- Config mode, hold button3 1 period (index 0->1), commit with button1 (M2 selected). Hold 1 period (->2), commit (M2 slave=S2). Hold 5 periods (2->0 via wrap). Run mode, rw_switch2=0, button2 1 period -> m2_busy high exactly 3 ticks; S2[0] = wdata.
- M1 with N=10 (field 3 = 10, addr=0, wdata=0x05): write -> m1_busy 13 ticks, S1[0..10] = 0x05..0x0F. Then read (rw_switch1=1) -> 13 ticks, rd_data ends at 0x0F.
- M1 and M2 start on the same tick, each with N=0 -> M1 finishes after 3 ticks; m2_busy stays high and finishes 2 ticks later.
- Button1 pressed while m1_busy -> ignored; busy duration unchanged.
- rst asserted mid-burst -> busy=0 next clock; a new start works normally.
- enable=0 for 20 clocks mid-transaction -> scaled_clk and FSMs frozen, then resume with the correct remaining beat count.
